mlcd_gram_reader: RTL

- Reads pixel data back from the GRAM of the 8080-style MCU TFT-LCD. It is the read-side counterpart of the LCD pixel write path.
- Sequence: issues the memory-read command, performs the controller's mandatory dummy read, then streams N pixels out over a valid/ready interface.
- Sits beside the LCD write driver on the 50 MHz LCD clock domain and shares the mlcd bus through the top-level mux. The top level gates mux ownership with busy.

---
 rtl/mlcd_gram_reader.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mlcd_gram_reader.sv
// Reads pixels back from 8080-style TFT-LCD GRAM: memory-read command, dummy read, then N pixels
// streamed over valid/ready. Define MLCD_RD_RGB888_EN for two strobes per pixel packed to RGB565.
module mlcd_gram_reader #(
    parameter logic [15:0] CMD_READ  = 16'h2E00,
    parameter int unsigned T_WR_LOW  = 2,
    parameter int unsigned T_WR_HIGH = 2,
    parameter int unsigned T_RD_LOW  = 4,
    parameter int unsigned T_RD_HIGH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [18:0] num_pixels_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic        mlcd_cs_n_o,
    output logic        mlcd_wr_n_o,
    output logic        mlcd_rd_n_o,
    output logic        mlcd_rs_o,
    output logic [15:0] mlcd_data_out_o,
    output logic        mlcd_data_oe_o,
    input  logic [15:0] mlcd_data_in_i
);

    localparam logic [7:0] WrLowLd  = 8'(T_WR_LOW - 1);
    localparam logic [7:0] WrHighLd = 8'(T_WR_HIGH - 1);
    localparam logic [7:0] RdLowLd  = 8'(T_RD_LOW - 1);
    localparam logic [7:0] RdHighLd = 8'(T_RD_HIGH - 1);

    typedef enum logic [3:0] {
        StIdle,
        StCmdWr,
        StCmdHold,
        StTurn,
        StDummyLow,
        StDummyHigh,
        StRdWait,
        StRdLow,
        StRdHigh,
        StFinish
    } state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [18:0] count_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] pix_data_q;
    logic        pix_valid_q;
    logic        cs_n_q;
    logic        wr_n_q;
    logic        rd_n_q;
    logic        rs_q;
    logic [15:0] data_out_q;
    logic        data_oe_q;

    logic        cnt_zero;
    logic        slot_free;
    logic        last_word;
    logic [15:0] pix_word;

    assign cnt_zero  = (cnt_q == 8'd0);
    // The output register can take a new pixel if empty or being drained this cycle.
    assign slot_free = !pix_valid_q || pix_ready_i;

`ifdef MLCD_RD_RGB888_EN
    logic        word1_q;
    logic [10:0] rg_q;
    logic        unused_data_in;

    assign last_word      = word1_q;
    assign pix_word       = {rg_q, mlcd_data_in_i[15:11]};
    assign unused_data_in = ^{mlcd_data_in_i[10:8], mlcd_data_in_i[1:0]};
`else
    assign last_word = 1'b1;
    assign pix_word  = mlcd_data_in_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            count_q     <= 19'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_data_q  <= 16'h0000;
            pix_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            rs_q        <= 1'b1;
            data_out_q  <= 16'h0000;
            data_oe_q   <= 1'b0;
`ifdef MLCD_RD_RGB888_EN
            word1_q     <= 1'b0;
            rg_q        <= 11'd0;
`endif
        end else begin
            done_q <= 1'b0;
            if (pix_valid_q && pix_ready_i) begin
                pix_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (num_pixels_i == 19'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            count_q    <= num_pixels_i;
                            busy_q     <= 1'b1;
                            cs_n_q     <= 1'b0;
                            rs_q       <= 1'b0;
                            data_oe_q  <= 1'b1;
                            data_out_q <= CMD_READ;
                            wr_n_q     <= 1'b0;
                            cnt_q      <= WrLowLd;
                            state_q    <= StCmdWr;
                        end
                    end
                end

                StCmdWr: begin
                    if (cnt_zero) begin
                        wr_n_q  <= 1'b1;
                        cnt_q   <= WrHighLd;
                        state_q <= StCmdHold;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StCmdHold: begin
                    if (cnt_zero) begin
                        rs_q       <= 1'b1;
                        data_oe_q  <= 1'b0;
                        data_out_q <= 16'h0000;
                        state_q    <= StTurn;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                // Bus released for one full cycle before the panel starts driving it.
                StTurn: begin
                    rd_n_q  <= 1'b0;
                    cnt_q   <= RdLowLd;
                    state_q <= StDummyLow;
                end

                StDummyLow: begin
                    if (cnt_zero) begin
                        rd_n_q  <= 1'b1;
                        cnt_q   <= RdHighLd;
                        state_q <= StDummyHigh;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StDummyHigh: begin
                    if (cnt_zero) begin
                        if (slot_free) begin
                            rd_n_q  <= 1'b0;
                            cnt_q   <= RdLowLd;
                            state_q <= StRdLow;
                        end else begin
                            state_q <= StRdWait;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StRdWait: begin
                    if (slot_free) begin
                        rd_n_q  <= 1'b0;
                        cnt_q   <= RdLowLd;
                        state_q <= StRdLow;
                    end
                end

                StRdLow: begin
                    if (cnt_zero) begin
                        rd_n_q  <= 1'b1;
                        cnt_q   <= RdHighLd;
                        state_q <= StRdHigh;
                        if (last_word) begin
                            pix_data_q  <= pix_word;
                            pix_valid_q <= 1'b1;
                        end
`ifdef MLCD_RD_RGB888_EN
                        if (!word1_q) begin
                            rg_q <= {mlcd_data_in_i[15:11], mlcd_data_in_i[7:2]};
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StRdHigh: begin
                    if (cnt_zero) begin
`ifdef MLCD_RD_RGB888_EN
                        word1_q <= ~word1_q;
`endif
                        if (!last_word) begin
                            // Second half of a pixel goes out without waiting on the slot.
                            rd_n_q  <= 1'b0;
                            cnt_q   <= RdLowLd;
                            state_q <= StRdLow;
                        end else begin
                            count_q <= count_q - 19'd1;
                            if (count_q == 19'd1) begin
                                cs_n_q  <= 1'b1;
                                state_q <= StFinish;
                            end else if (slot_free) begin
                                rd_n_q  <= 1'b0;
                                cnt_q   <= RdLowLd;
                                state_q <= StRdLow;
                            end else begin
                                state_q <= StRdWait;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                StFinish: begin
                    if (slot_free) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pix_data_o      = pix_data_q;
    assign pix_valid_o     = pix_valid_q;
    assign mlcd_cs_n_o     = cs_n_q;
    assign mlcd_wr_n_o     = wr_n_q;
    assign mlcd_rd_n_o     = rd_n_q;
    assign mlcd_rs_o       = rs_q;
    assign mlcd_data_out_o = data_out_q;
    assign mlcd_data_oe_o  = data_oe_q;

    // Never drive the bus while the panel may be driving it.
    a_no_contention : assert property (@(posedge clk_i) disable iff (rst_i)
        !(!rd_n_q && data_oe_q));

    a_strobes_exclusive : assert property (@(posedge clk_i) disable iff (rst_i)
        !(!rd_n_q && !wr_n_q));

endmodule
